// File: rtl/code_sender.sv
// Transmitter for the 2-bit safe-lock symbol interface (00 idle, 01 A, 10 B, 11 C).
// Replays a stored combination on x1/x0, optionally separated by idle gaps.
module code_sender #(
   parameter int                LEN       = 5,
   parameter int                GAP       = 0,
   parameter logic [2*LEN-1:0]  INIT_CODE = 10'b01_10_11_10_01
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 load,
   input  logic [2*LEN-1:0]     load_code,
   output logic                 x1,
   output logic                 x0,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   localparam logic [2:0] LAST  = 3'(LEN - 1);
   localparam logic [3:0] GAP_N = 4'(GAP);

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [3:0]         gap_q, gap_d;
   logic [2*LEN-1:0]   code_q, code_d;
   logic [1:0]         sym_d;
   logic               busy_d, done_d, err_d;

   // A combination is usable only if no symbol is the idle code 00.
   function automatic logic code_ok(input logic [2*LEN-1:0] c);
      code_ok = 1'b1;
      for (int i = 0; i < LEN; i++) begin
         if (c[2*i +: 2] == 2'b00) code_ok = 1'b0;
      end
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         code_q  <= INIT_CODE;
         x1      <= 1'b0;
         x0      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         code_q  <= code_d;
         x1      <= sym_d[1];
         x0      <= sym_d[0];
         busy    <= busy_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      code_d  = code_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            gap_d = '0;
            if (load) begin
               if (code_ok(load_code)) code_d = load_code;
               else                    err_d  = 1'b1;
            end else if (start && !abort && code_ok(code_q)) begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (idx_q == LAST) begin
               state_d = S_DONE;
            end else if (GAP_N != 4'd0) begin
               state_d = S_GAP;
               gap_d   = GAP_N;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_GAP: begin
            if (gap_q <= 4'd1) begin
               state_d = S_SEND;
               idx_d   = idx_q + 3'd1;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
      // Outside IDLE the code register is frozen: any load is refused, abort wins.
      if (state_q != S_IDLE) begin
         err_d = load;
         if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            gap_d   = '0;
         end
      end
   end

   // Outputs are registered from the state being entered, so they align with it.
   always_comb begin
      sym_d  = 2'b00;
      busy_d = (state_d == S_SEND) || (state_d == S_GAP);
      done_d = (state_d == S_DONE);
      if (state_d == S_SEND) begin
         for (int i = 0; i < LEN; i++) begin
            if (idx_d == 3'(i)) sym_d = code_q[2*i +: 2];
         end
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_code_sender.sv
// Bench for code_sender: two instances (GAP=0 and GAP=2) share stimulus and are
// compared every cycle against a position-based model of the symbol stream.
module tb_code_sender;

   localparam int         LEN  = 5;
   localparam logic [9:0] INIT = 10'b01_10_11_10_01;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, abort, load;
   logic [9:0] load_code;
   logic       x1_o [2];
   logic       x0_o [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic       err_o [2];
   logic [1:0] dbg0, dbg1;

   int errors = 0;
   int checks = 0;

   // model state: pos = -1 idle, else index into the expected stream
   int         pos [2];
   int         gapv [2];
   logic [9:0] mcode [2];
   logic       merr [2];

   always #5 clk = ~clk;

   code_sender #(.LEN(LEN), .GAP(0), .INIT_CODE(INIT)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .load(load),
      .load_code(load_code), .x1(x1_o[0]), .x0(x0_o[0]), .busy(busy_o[0]),
      .done(done_o[0]), .err(err_o[0]), .dbg_state(dbg0));

   code_sender #(.LEN(LEN), .GAP(2), .INIT_CODE(INIT)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .load(load),
      .load_code(load_code), .x1(x1_o[1]), .x0(x0_o[1]), .busy(busy_o[1]),
      .done(done_o[1]), .err(err_o[1]), .dbg_state(dbg1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic valid_code(input logic [9:0] c);
      valid_code = 1'b1;
      for (int i = 0; i < LEN; i++) if (c[2*i +: 2] == 2'b00) valid_code = 1'b0;
   endfunction

   // expected {x1,x0,busy,done}: symbols every GAP+1 cycles, then one done cycle
   function automatic logic [3:0] exp_out(input int d);
      int total;
      int g;
      g = gapv[d];
      total = LEN + (LEN - 1) * g;
      if (pos[d] < 0)               exp_out = 4'b0000;
      else if (pos[d] == total)     exp_out = 4'b0001;
      else if (pos[d] % (g + 1) == 0)
         exp_out = {mcode[d][2*(pos[d]/(g+1)) +: 2], 2'b10};
      else                          exp_out = 4'b0010;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         pos[d]   = -1;
         mcode[d] = INIT;
         merr[d]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      int total;
      for (int d = 0; d < 2; d++) begin
         total   = LEN + (LEN - 1) * gapv[d];
         merr[d] = 1'b0;
         if (pos[d] >= 0) begin
            merr[d] = load;
            if (abort || pos[d] == total) pos[d] = -1;
            else                          pos[d] = pos[d] + 1;
         end else if (load) begin
            if (valid_code(load_code)) mcode[d] = load_code;
            else                       merr[d]  = 1'b1;
         end else if (start && !abort) begin
            pos[d] = 0;
         end
      end
   endtask

   task automatic check_outs();
      logic [3:0] e;
      for (int d = 0; d < 2; d++) begin
         e = exp_out(d);
         check($sformatf("x1[%0d]", d),   32'(x1_o[d]),   32'(e[3]));
         check($sformatf("x0[%0d]", d),   32'(x0_o[d]),   32'(e[2]));
         check($sformatf("busy[%0d]", d), 32'(busy_o[d]), 32'(e[1]));
         check($sformatf("done[%0d]", d), 32'(done_o[d]), 32'(e[0]));
         check($sformatf("err[%0d]", d),  32'(err_o[d]),  32'(merr[d]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((pos[0] != -1 || pos[1] != -1) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) check("idle_timeout", 32'(n), 32'd0);
      step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      gapv[0] = 0;
      gapv[1] = 2;
      reset = 1'b0;
      start = 1'b0; abort = 1'b0; load = 1'b0; load_code = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outs();
      @(negedge clk);
      reset = 1'b1;
      step();

      // default code, single start
      pulse_start();
      wait_idle();

      // valid load then start
      load = 1'b1; load_code = 10'b11_11_01_10_01;
      step();
      load = 1'b0;
      step();
      pulse_start();
      wait_idle();

      // rejected load (symbol 2 = 00) then start with retained code
      load = 1'b1; load_code = 10'b11_11_00_10_01;
      step();
      load = 1'b0;
      pulse_start();
      wait_idle();

      // load and start together: load wins
      load = 1'b1; start = 1'b1; load_code = INIT;
      step();
      load = 1'b0; start = 1'b0;
      step();

      // abort while the third symbol is on the wire (GAP=0 instance)
      pulse_start();
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      wait_idle();
      pulse_start();
      wait_idle();

      // abort in IDLE blocks start
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      step();

      // start held for 20 cycles with loads during busy
      load_code = 10'b10_10_10_10_10;
      for (int i = 0; i < 20; i++) begin
         start = 1'b1;
         load  = (i == 3 || i == 9);
         step();
      end
      start = 1'b0; load = 1'b0;
      wait_idle();

      // asynchronous reset in the middle of a gap
      load = 1'b1; load_code = 10'b11_11_11_11_11;
      step();
      load = 1'b0;
      pulse_start();
      step();
      #2 reset = 1'b0;
      model_reset();
      #1;
      check_outs();
      @(negedge clk);
      reset = 1'b1;
      step();
      pulse_start();
      wait_idle();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 24) == 0);
         load  = ($urandom_range(0, 11) == 0);
         for (int s = 0; s < LEN; s++)
            load_code[2*s +: 2] = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         step();
      end
      start = 1'b0; abort = 1'b0; load = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
